dp_cmd_sequencer: RTL and testbench

- Upstream command front-end for the datapath/control-unit pair.
- Buffers operation commands {op, in1, in2} in a small FIFO and issues each as a one-cycle go pulse with operands held stable.
- Waits for done, captures the 3-bit result, and presents it on a valid/ready result port.
- Serialises back-to-back requests so the CU never sees go while busy.

---
 rtl/dp_cmd_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dp_cmd_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dp_cmd_sequencer
// Desc     : Command FIFO and go/done sequencer in front of the datapath CU.
//            Optional WAIT timeout with sticky err: define DPSEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dp_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [2:0]              cmd_in1,
   input  logic [2:0]              cmd_in2,
   output logic                    go,
   output logic [1:0]              op,
   output logic [2:0]              in1,
   output logic [2:0]              in2,
   input  logic                    done,
   input  logic [2:0]              result,
   output logic                    res_valid,
   output logic [2:0]              res_data,
   output logic [1:0]              res_op,
   input  logic                    res_ready,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    err
);

   localparam int                  c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]    c_FULL  = (c_PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("dp_cmd_sequencer: DEPTH must be a power of 2 and at least 2");
      end
      if (TIMEOUT < 1) begin : g_bad_timeout
         $error("dp_cmd_sequencer: TIMEOUT must be at least 1");
      end
   endgenerate

   state_t               r_state;
   state_t               w_next;
   logic [1:0]           r_mem_op  [DEPTH];
   logic [2:0]           r_mem_in1 [DEPTH];
   logic [2:0]           r_mem_in2 [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W:0]     r_count;
   logic [1:0]           r_op;
   logic [2:0]           r_in1;
   logic [2:0]           r_in2;
   logic [2:0]           r_res_data;
   logic [1:0]           r_res_op;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_capture;
   logic                 w_timeout;

   assign cmd_ready = (r_count != c_FULL);
   assign w_push    = cmd_valid && cmd_ready;
   assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
   assign w_capture = (r_state == S_WAIT) && done;

   // Storage needs no reset: occupancy alone decides what is readable.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_op[r_wr_ptr]  <= cmd_op;
         r_mem_in1[r_wr_ptr] <= cmd_in1;
         r_mem_in2[r_wr_ptr] <= cmd_in2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Operands are latched only on pop, so they stay stable for the whole CU run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op       <= '0;
         r_in1      <= '0;
         r_in2      <= '0;
         r_res_data <= '0;
         r_res_op   <= '0;
      end else begin
         if (w_pop) begin
            r_op  <= r_mem_op[r_rd_ptr];
            r_in1 <= r_mem_in1[r_rd_ptr];
            r_in2 <= r_mem_in2[r_rd_ptr];
         end
         if (w_capture) begin
            r_res_data <= result;
            r_res_op   <= r_op;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_count != '0) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT: begin
            if (done)           w_next = S_HOLD;
            else if (w_timeout) w_next = S_IDLE;
         end
         S_HOLD:  if (res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

`ifdef DPSEQ_TIMEOUT_EN
   localparam int                   c_TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [c_TMO_W-1:0]   c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

   logic [c_TMO_W-1:0]  r_tmo_cnt;
   logic                r_err;

   // done on the final WAIT cycle still wins because w_timeout requires !done.
   assign w_timeout = (r_state == S_WAIT) && !done && (r_tmo_cnt == c_TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         if (r_state == S_ISSUE)     r_tmo_cnt <= '0;
         else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
         if (w_timeout)              r_err     <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = 1'b0;
`endif

   assign go        = (r_state == S_ISSUE);
   assign busy      = (r_state != S_IDLE);
   assign res_valid = (r_state == S_HOLD);
   assign op        = r_op;
   assign in1       = r_in1;
   assign in2       = r_in2;
   assign res_data  = r_res_data;
   assign res_op    = r_res_op;
   assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_cmd_sequencer
// Desc     : Randomised bench for dp_cmd_sequencer with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_cmd_sequencer;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = '0;
   logic [2:0] cmd_in1 = '0;
   logic [2:0] cmd_in2 = '0;
   logic       go;
   logic [1:0] op;
   logic [2:0] in1;
   logic [2:0] in2;
   logic       done = 1'b0;
   logic [2:0] result = '0;
   logic       res_valid;
   logic [2:0] res_data;
   logic [1:0] res_op;
   logic       res_ready = 1'b0;
   logic       busy;
   logic [2:0] count;
   logic       err;

   always #5 clk = ~clk;

   dp_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_in1(cmd_in1), .cmd_in2(cmd_in2),
      .go(go), .op(op), .in1(in1), .in2(in2),
      .done(done), .result(result),
      .res_valid(res_valid), .res_data(res_data), .res_op(res_op), .res_ready(res_ready),
      .busy(busy), .count(count), .err(err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] a;
      logic [2:0] b;
   } cmd_t;

   // Model: commands queued but not yet issued, the one the CU is running, and
   // the result waiting to be taken.
   cmd_t       q[$];
   cmd_t       cur = '0;
   bit         outstanding = 0;
   bit         pending = 0;
   bit         err_exp = 0;
   int         wait_idx = 0;
   int         lat = 0;
   logic [2:0] cu_res = '0;
   logic [1:0] exp_res_op = '0;
   logic [2:0] exp_res_d = '0;

   int   p_push = 0, p_ready = 0, lat_max = 6, stale_pct = 50;
   int   force_lat = -1, force_res = -1;
   bit   allow_never = 0;
   bit   dir_push = 0;
   cmd_t dir_cmd = '0;

   task automatic check_outputs(input string ph);
      chk_eq({ph, "_op"},        int'(op),        int'(cur.op));
      chk_eq({ph, "_in1"},       int'(in1),       int'(cur.a));
      chk_eq({ph, "_in2"},       int'(in2),       int'(cur.b));
      chk_eq({ph, "_count"},     int'(count),     q.size());
      chk_eq({ph, "_cmd_ready"}, int'(cmd_ready), int'(q.size() != DEPTH));
      chk_eq({ph, "_busy"},      int'(busy),      int'(outstanding));
      chk_eq({ph, "_res_valid"}, int'(res_valid), int'(pending));
      chk_eq({ph, "_err"},       int'(err),       int'(err_exp));
      if (pending) begin
         chk_eq({ph, "_res_data"}, int'(res_data), int'(exp_res_d));
         chk_eq({ph, "_res_op"},   int'(res_op),   int'(exp_res_op));
      end
   endtask

   // One clock: choose inputs at a falling edge, then check at the next one.
   task automatic tick();
      cmd_t c;
      bit   do_push;
      bit   exp_go;
      exp_go = !outstanding && (q.size() != 0);
      if (dir_push) begin
         do_push  = 1'b1;
         c        = dir_cmd;
         dir_push = 1'b0;
      end else begin
         do_push = ($urandom_range(99) < p_push);
         c.op    = 2'($urandom);
         c.a     = 3'($urandom);
         c.b     = 3'($urandom);
      end
      cmd_valid = do_push;
      cmd_op    = c.op;
      cmd_in1   = c.a;
      cmd_in2   = c.b;
      if (do_push && q.size() != DEPTH) q.push_back(c);

      res_ready = ($urandom_range(99) < p_ready);
      done      = 1'b0;
      result    = 3'($urandom);
      if (pending && res_ready) begin
         pending     = 0;
         outstanding = 0;
      end else if (outstanding && !pending) begin
         if (wait_idx == 0) begin
            done = ($urandom_range(99) < stale_pct);
         end else if (wait_idx == lat) begin
            done       = 1'b1;
            result     = cu_res;
            pending    = 1;
            exp_res_op = cur.op;
            exp_res_d  = cu_res;
         end
`ifdef DPSEQ_TIMEOUT_EN
         else if (wait_idx == TIMEOUT) begin
            err_exp     = 1;
            outstanding = 0;
         end
`endif
         wait_idx++;
      end

      @(negedge clk);
      chk_eq("go", int'(go), int'(exp_go));
      if (exp_go) begin
         cur         = q.pop_front();
         outstanding = 1;
         wait_idx    = 0;
         if (force_lat >= 0)                                lat = force_lat;
         else if (allow_never && $urandom_range(99) < 25)   lat = 1000;
         else                                               lat = $urandom_range(lat_max, 1);
         cu_res = (force_res >= 0) ? 3'(force_res) : 3'($urandom);
      end
      check_outputs("run");
   endtask

   task automatic clear_model();
      q.delete();
      cur         = '0;
      outstanding = 0;
      pending     = 0;
      err_exp     = 0;
      wait_idx    = 0;
   endtask

   initial begin
      bit reached;
      repeat (2) @(negedge clk);
      check_outputs("por");
      rst_n = 1'b1;

      // Single op {1,3,2}, result 5 after 5 WAIT cycles, stale done in ISSUE.
      stale_pct = 100;
      force_lat = 5;
      force_res = 5;
      dir_cmd   = '{op: 2'b01, a: 3'd3, b: 3'd2};
      dir_push  = 1'b1;
      repeat (12) tick();
      p_ready = 100;
      repeat (3) tick();

      // Stale done then 0 then done on the second WAIT cycle.
      p_ready  = 0;
      force_lat = 2;
      force_res = 6;
      dir_cmd  = '{op: 2'b10, a: 3'd7, b: 3'd1};
      dir_push = 1'b1;
      repeat (8) tick();
      p_ready = 100;
      repeat (3) tick();

      // Fill beyond DEPTH with results blocked, then drain.
      force_lat = -1;
      force_res = -1;
      stale_pct = 50;
      p_push    = 100;
      p_ready   = 0;
      repeat (20) tick();
      p_ready = 100;
      repeat (10) tick();
      p_push = 0;
      repeat (40) tick();

      // Random traffic.
      p_push  = 40;
      p_ready = 60;
      lat_max = 6;
      repeat (600) tick();

`ifdef DPSEQ_TIMEOUT_EN
      allow_never = 1;
      lat_max     = TIMEOUT;
      repeat (600) tick();
      allow_never = 0;
      lat_max     = 6;
`endif

      // Asynchronous reset while the CU is mid-WAIT with commands queued.
      p_push    = 100;
      p_ready   = 100;
      force_lat = 30;
      reached   = 0;
      for (int i = 0; i < 60; i++) begin
         if (outstanding && !pending && wait_idx >= 2 && q.size() >= 1) begin
            reached = 1;
            break;
         end
         tick();
      end
      chk_eq("reset_setup_reached", int'(reached), 1);
      #2;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      done      = 1'b0;
      res_ready = 1'b0;
      #1;
      clear_model();
      check_outputs("async_rst");
      @(negedge clk);
      check_outputs("in_rst");
      rst_n     = 1'b1;
      force_lat = -1;
      p_push    = 40;
      p_ready   = 60;
      repeat (200) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
